beam_timeline_engine: RTL
=========================

// Module: beam_timeline_engine
// PURPOSE
//  Streaming successor of the row-per-cycle beam/splitter solver. Consumes one grid row per handshake beat.
//  Tracks a saturating per-column beam multiplicity, not a 1-bit mask.
//  Reports both the number of splitters hit (part 1) and the number of distinct timelines (part 2) in one pass.
//  Sits between the grid row streamer and the result/UART reporter.
// PARAMETERS
//  WIDTH     141  grid columns; row_data is 2*WIDTH bits, 2-bit code per column
//  CNT_W     64   per-column multiplicity / timeline counter width (saturating)
//  HIT_W     64   splitters_hit counter width (wraps modulo 2^HIT_W)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          begin new grid; honoured only in IDLE or DONE
//  row_valid      in   1          row_data/row_last valid
//  row_ready      out  1          engine accepts row this cycle
//  row_data       in   2*WIDTH    column i code at [2i+:2]: 0 '.', 1 '^' split, 2 'S' source, 3 treated as '.'
//  row_last       in   1          accepted row is final grid row
//  busy           out  1          high in RUN or SUM
//  done           out  1          results valid; held until start or rst
//  splitters_hit  out  HIT_W      count of (column,row) splitters reached by >=1 beam
//  timelines      out  CNT_W      total beam multiplicity leaving the grid (bottom + side exits)
//  overflow       out  1          sticky: any saturation of any CNT_W quantity this grid
// BEHAVIOUR
//  Reset: state=IDLE; row_ready, busy, done, overflow = 0; splitters_hit, timelines = 0; all col counts = 0.
//  FSM:
//   IDLE  -start-> RUN
//   RUN   -row beat with row_last-> SUM
//   SUM   -col index == WIDTH-1-> DONE
//   DONE  -start-> RUN
//  On start: clear counts, hits, timelines, overflow, exit accumulator; done falls in the same edge.
//  start in RUN/SUM is ignored. row_ready = (state==RUN); beat = row_valid & row_ready.
//  Per beat, per column i, with c[i] the registered count:
//   e[i] = c[i] + (code==S); saturating.
//   split[i] = (code==^) & e[i]!=0.
//   pass[i] = (code!=^) ? e[i] : 0.
//   next[i] = pass[i] + (split[i-1]?e[i-1]:0) + (split[i+1]?e[i+1]:0); saturating at 2^CNT_W-1.
//   Column 0 left throw and column WIDTH-1 right throw exit the grid: add their e into exit_acc (saturating).
//   splitters_hit += popcount(split); count ignores multiplicity.
//  Beat updates all state in one cycle; no beat -> no state change. Back-to-back beats are supported at full rate.
//  SUM: one column per cycle, timelines = exit_acc + sum c[i], saturating.
//   done rises exactly WIDTH cycles after the row_last beat edge.
//  Any saturation sets overflow; it stays set until start/rst. Saturated values clamp at all-ones.
//  rst mid-RUN/SUM: immediate return to reset state, partial results discarded.
//  Bit-compatibility: splitters_hit equals the part-1 mask-based answer for any grid.
// STRUCTURE
//  beam_defs.vh: CODE_EMPTY=2'd0, CODE_SPLIT=2'd1, CODE_SOURCE=2'd2; state encodings ST_IDLE/ST_RUN/ST_SUM/ST_DONE.
//  Sub-module beam_row_step: combinational. Inputs: counts vector and row_data.
//   Outputs: next counts, exit_left/exit_right, hit popcount, sat flag. Parametrised WIDTH and CNT_W.
//  Top holds the FSM, count registers, SUM column index, and accumulators.
// TESTING (WIDTH=5 unless noted)
//  Test 1, basic: rows "..S..", ".....", "..^..", ".^.^." (last).
//   -> splitters_hit=3, timelines=4, overflow=0; done WIDTH cycles after last beat.
//  Test 2, edge exit: WIDTH=3, rows "S..", "^.." (last).
//   -> splitters_hit=1, timelines=2 (1 side exit + 1 in col 1).
//  Test 3, gapped stream: Test 1 rows with random row_valid gaps and start pulsed during RUN.
//   -> identical results, start ignored.
//  Test 4, saturation: CNT_W=4, WIDTH=9. Row "....S....", then "....^....", then alternating full-split rows.
//   -> once total>15: timelines=15, overflow=1, sticky.
//  Test 5, reset mid-RUN: rst after 2 beats of Test 1.
//   -> next cycle all outputs 0, row_ready=0.
//   -> start + full Test 1 gives 3/4.
//  Test 6, restart from DONE: after Test 1, start then Test 2 grid.
//   -> 1/2, no carry-over; done low from start edge until new SUM completes.

Source files
------------

// File: rtl/beam_timeline_engine_pkg.sv
// Shared definitions for the beam timeline engine.
//   cell_code_e : 2-bit per-column grid cell code carried on row_data
//   eng_state_e : engine control states
package beam_timeline_engine_pkg;

    // Code 3 is not a real cell type; the datapath treats it like an empty cell.
    typedef enum logic [1:0] {
        CODE_EMPTY  = 2'd0,
        CODE_SPLIT  = 2'd1,
        CODE_SOURCE = 2'd2,
        CODE_RSVD   = 2'd3
    } cell_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SUM  = 2'd2,
        ST_DONE = 2'd3
    } eng_state_e;

endpackage

// File: rtl/beam_timeline_engine_row_step.sv
// Combinational single-row beam propagation step.
//   cnt_in     : per-column beam multiplicity entering the row
//   row_data   : 2-bit cell code per column, column i at [2i+:2]
//   cnt_out    : per-column multiplicity leaving the row (saturating)
//   exit_left  : multiplicity thrown off the left edge by a splitter in column 0
//   exit_right : multiplicity thrown off the right edge by a splitter in column WIDTH-1
//   hit_cnt    : number of splitters in this row reached by at least one beam
//   sat        : some quantity in this step clamped at all-ones
module beam_timeline_engine_row_step
    import beam_timeline_engine_pkg::*;
#(
    parameter int WIDTH = 141,
    parameter int CNT_W = 64,
    parameter int HITC_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0][CNT_W-1:0] cnt_in,
    input  logic [2*WIDTH-1:0]          row_data,
    output logic [WIDTH-1:0][CNT_W-1:0] cnt_out,
    output logic [CNT_W-1:0]            exit_left,
    output logic [CNT_W-1:0]            exit_right,
    output logic [HITC_W-1:0]           hit_cnt,
    output logic                        sat
);

    // MSB of the result flags a clamp; low CNT_W bits hold the clamped sum.
    function automatic logic [CNT_W:0] add_sat(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            add_sat = {1'b1, {CNT_W{1'b1}}};
        end else begin
            add_sat = s;
        end
    endfunction

    logic [WIDTH-1:0][CNT_W-1:0] e_s;       // count after source injection
    logic [WIDTH-1:0][CNT_W-1:0] from_l_s;  // thrown in from the left neighbour
    logic [WIDTH-1:0][CNT_W-1:0] from_r_s;  // thrown in from the right neighbour
    logic [WIDTH-1:0]            split_s;
    logic [CNT_W-1:0]            pass_s;
    logic [CNT_W:0]              t0_s;
    logic [CNT_W:0]              t1_s;

    // Inject sources, detect live splitters, then merge pass-through and throws per column.
    always_comb begin
        e_s        = '0;
        from_l_s   = '0;
        from_r_s   = '0;
        split_s    = '0;
        pass_s     = '0;
        t0_s       = '0;
        t1_s       = '0;
        cnt_out    = '0;
        exit_left  = '0;
        exit_right = '0;
        hit_cnt    = '0;
        sat        = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (row_data[2*i +: 2] == CODE_SOURCE) begin
                t0_s   = add_sat(cnt_in[i], CNT_W'(1));
                e_s[i] = t0_s[CNT_W-1:0];
                sat    = sat | t0_s[CNT_W];
            end else begin
                e_s[i] = cnt_in[i];
            end
            // A splitter counts once per row however many beams reach it.
            split_s[i] = (row_data[2*i +: 2] == CODE_SPLIT) && (e_s[i] != '0);
            hit_cnt    = hit_cnt + HITC_W'(split_s[i]);
        end
        for (int i = 1; i < WIDTH; i++) begin
            from_l_s[i] = split_s[i-1] ? e_s[i-1] : '0;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            from_r_s[i] = split_s[i+1] ? e_s[i+1] : '0;
        end
        exit_left  = split_s[0]       ? e_s[0]       : '0;
        exit_right = split_s[WIDTH-1] ? e_s[WIDTH-1] : '0;
        for (int i = 0; i < WIDTH; i++) begin
            pass_s     = (row_data[2*i +: 2] != CODE_SPLIT) ? e_s[i] : '0;
            t0_s       = add_sat(pass_s, from_l_s[i]);
            t1_s       = add_sat(t0_s[CNT_W-1:0], from_r_s[i]);
            cnt_out[i] = t1_s[CNT_W-1:0];
            sat        = sat | t0_s[CNT_W] | t1_s[CNT_W];
        end
    end

endmodule

// File: rtl/beam_timeline_engine.sv
// Streaming beam/splitter solver: one grid row per row_valid/row_ready beat,
// per-column saturating beam multiplicity, splitter-hit and timeline totals.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a new grid (only honoured in IDLE or DONE)
//   row_valid/row_ready/row_data/row_last : row stream handshake
//   busy, done     : RUN/SUM activity, results-valid (held until start/rst)
//   splitters_hit  : live splitters reached (wraps), timelines : exits + final counts
//   overflow       : sticky saturation flag for the current grid
module beam_timeline_engine
    import beam_timeline_engine_pkg::*;
#(
    parameter int WIDTH = 141,
    parameter int CNT_W = 64,
    parameter int HIT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [2*WIDTH-1:0]   row_data,
    input  logic                 row_last,
    output logic                 busy,
    output logic                 done,
    output logic [HIT_W-1:0]     splitters_hit,
    output logic [CNT_W-1:0]     timelines,
    output logic                 overflow
);

    localparam int HITC_W = $clog2(WIDTH + 1);
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [CNT_W:0] add_sat(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            add_sat = {1'b1, {CNT_W{1'b1}}};
        end else begin
            add_sat = s;
        end
    endfunction

    eng_state_e                  state_r;
    eng_state_e                  state_nxt_s;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0]            idx_r;
    logic [HIT_W-1:0]            hits_r;
    logic [CNT_W-1:0]            tl_r;      // exit accumulator in RUN, running total in SUM
    logic                        ovf_r;
    logic                        row_ready_r;
    logic                        busy_r;
    logic                        done_r;

    logic [WIDTH-1:0][CNT_W-1:0] step_cnt_s;
    logic [CNT_W-1:0]            exit_l_s;
    logic [CNT_W-1:0]            exit_r_s;
    logic [HITC_W-1:0]           step_hit_s;
    logic                        step_sat_s;
    logic [CNT_W:0]              ex0_s;
    logic [CNT_W:0]              ex1_s;
    logic [CNT_W:0]              sum_s;
    logic                        beat_s;
    logic                        start_ok_s;

    assign beat_s     = row_valid & row_ready_r;
    assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    beam_timeline_engine_row_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .cnt_in     (cnt_r),
        .row_data   (row_data),
        .cnt_out    (step_cnt_s),
        .exit_left  (exit_l_s),
        .exit_right (exit_r_s),
        .hit_cnt    (step_hit_s),
        .sat        (step_sat_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (beat_s && row_last) state_nxt_s = ST_SUM;
                else                    state_nxt_s = ST_RUN;
            end
            ST_SUM: begin
                if (idx_r == IDX_W'(WIDTH - 1)) state_nxt_s = ST_DONE;
                else                            state_nxt_s = ST_SUM;
            end
            ST_DONE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Saturating adders for edge exits (RUN) and the column reduction (SUM).
    always_comb begin
        ex0_s = add_sat(tl_r, exit_l_s);
        ex1_s = add_sat(ex0_s[CNT_W-1:0], exit_r_s);
        sum_s = add_sat(tl_r, cnt_r[idx_r]);
    end

    // State register; status outputs follow the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            row_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            row_ready_r <= (state_nxt_s == ST_RUN);
            busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SUM);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Column counts, hit count, timeline accumulator and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            idx_r  <= '0;
            hits_r <= '0;
            tl_r   <= '0;
            ovf_r  <= 1'b0;
        end else if (start_ok_s) begin
            cnt_r  <= '0;
            idx_r  <= '0;
            hits_r <= '0;
            tl_r   <= '0;
            ovf_r  <= 1'b0;
        end else if ((state_r == ST_RUN) && beat_s) begin
            cnt_r  <= step_cnt_s;
            idx_r  <= '0;
            hits_r <= hits_r + HIT_W'(step_hit_s);
            tl_r   <= ex1_s[CNT_W-1:0];
            ovf_r  <= ovf_r | step_sat_s | ex0_s[CNT_W] | ex1_s[CNT_W];
        end else if (state_r == ST_SUM) begin
            idx_r  <= idx_r + IDX_W'(1);
            tl_r   <= sum_s[CNT_W-1:0];
            ovf_r  <= ovf_r | sum_s[CNT_W];
        end
    end

    assign row_ready     = row_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign splitters_hit = hits_r;
    assign timelines     = tl_r;
    assign overflow      = ovf_r;

endmodule
